counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
Scheduler for the two-channel event counter (sel/en/sync-reset interface, 64-bit output0/output1). Two requesters each ask for a burst of N count enables on their own channel. A separate clear requester can also reset the counter. The block arbitrates round-robin between the two channels, drives the counter's sel/en/reset pins, and returns ack/done handshakes. It sits between the requesting logic and one counter instance.

Parameters:
LEN_W, 8, width of burst-length inputs and of the internal remaining-count register

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
req0  input  1  channel-0 burst request, level, held until ack0
len0  input  LEN_W  channel-0 burst length, sampled in the ack0 cycle
req1  input  1  channel-1 burst request, level, held until ack1
len1  input  LEN_W  channel-1 burst length, sampled in the ack1 cycle
clr_req  input  1  counter-clear request, level, held until clr_ack
ack0  output  1  one-cycle pulse: channel-0 request accepted
ack1  output  1  one-cycle pulse: channel-1 request accepted
done0  output  1  one-cycle pulse on the final enable of a channel-0 burst
done1  output  1  one-cycle pulse on the final enable of a channel-1 burst
clr_ack  output  1  one-cycle pulse, coincident with cnt_reset
busy  output  1  high when state != IDLE
cnt_sel  output  1  to counter sel; equals current burst owner
cnt_en  output  1  to counter en
cnt_reset  output  1  to counter reset (synchronous at the counter)

Behaviour:
- Reset (async): state=IDLE, remaining=0, owner=0, last=1, so channel 0 wins the first tie. All outputs 0 while reset is high and on release.
- State IDLE, evaluated each cycle in priority order:
  - clr_req=1: go to CLEAR. Clear beats both channel requests.
  - Only one of req0/req1 high: grant it.
  - Both high: grant ~last.
  - Grant cycle: ackX=1, owner=X, last=X, remaining=lenX.
  - lenX!=0: next state RUN.
  - lenX==0: doneX=1 in the same cycle, state stays IDLE, no cnt_en.
- State RUN:
  - cnt_en=1 and cnt_sel=owner, both decoded from registered state; remaining decrements each cycle.
  - When remaining==1: done<owner>=1 in that cycle, next state IDLE.
  - Exactly len cycles of cnt_en per burst.
  - No preemption: req and clr_req are ignored until the burst ends.
- State CLEAR: cnt_reset=1 and clr_ack=1 for exactly one cycle, then IDLE.
- Minimum gap between bursts is one cnt_en-low cycle (the IDLE arbitration cycle). Grants are never issued back-to-back from RUN.
- A request dropped before its ack is simply not granted; no error.
- Reset asserted mid-burst or mid-clear: aborts at once; no done or clr_ack; last returns to 1.
- Counter semantics the team relies on:
  - Channel-1 enables zero output0.
  - output1 first increments on the 4th channel-1 enable after counter reset, then every 3rd.
  - The scheduler does not compensate for either effect.
- ack, done and clr_ack are mutually exclusive per channel, except the len==0 case (ack and done together).

Test Plan:
- Reset, then req0=1 with len0=5 (ack at cycle T) -> ack0@T; cnt_en=1, cnt_sel=0 for T+1..T+5; done0@T+5; busy T+1..T+5; counter output0=5, output1=0.
- req0 and req1 both high from reset, len0=len1=2 -> grant order 0 then 1; cnt_en 1,1,0,1,1 with cnt_sel 0,0,x,1,1; done0 then done1; next tie goes to channel 0 (last=1).
- clr_req and req1 (len1=3) rise in the same IDLE cycle -> cnt_reset and clr_ack one cycle; ack1 the following cycle; then 3 enables with sel=1.
- clr_req raised during the 2nd cycle of a len0=4 burst -> all 4 enables and done0 occur first; cnt_reset one cycle after the IDLE cycle that follows the burst.
- len1=0 request -> ack1 and done1 in the same cycle, cnt_en never high, busy stays 0; len=255 with LEN_W=8 -> 255 enables, no wrap.
- Reset pulsed after 2 of 6 enables of a channel-1 burst -> all outputs drop to 0 immediately, no done1. Separately, from counter reset, a req1 burst with len1=7 -> counter output1=2, output0=0.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin burst scheduler for the two-channel event counter.
// Grants burst requests, issues counter clears, and sequences sel/en/reset.
module counter_sched #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    input  logic             clr_req,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic             clr_ack,
    output logic             busy,
    output logic             cnt_sel,
    output logic             cnt_en,
    output logic             cnt_reset
);

    // state | meaning
    // IDLE  | arbitrate: clear first, then round-robin between channels
    // RUN   | one counter enable per cycle for the owner until remaining hits 1
    // CLEAR | single-cycle synchronous reset of the counter
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             gch;
    logic [LEN_W-1:0] glen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        owner_d     = owner_q;
        last_d      = last_q;
        ack0        = 1'b0;
        ack1        = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        clr_ack     = 1'b0;
        cnt_en      = 1'b0;
        cnt_reset   = 1'b0;
        gch         = 1'b0;
        glen        = '0;

        case (state_q)
            IDLE: begin
                // Grants are Mealy outputs; hold them off while reset is asserted.
                if (!reset) begin
                    if (clr_req) begin
                        state_d = CLEAR;
                    end else if (req0 || req1) begin
                        gch         = (req0 && req1) ? ~last_q : req1;
                        glen        = gch ? len1 : len0;
                        owner_d     = gch;
                        last_d      = gch;
                        remaining_d = glen;
                        ack0        = ~gch;
                        ack1        = gch;
                        if (glen == '0) begin
                            done0 = ~gch;
                            done1 = gch;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                cnt_en      = 1'b1;
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    done0   = ~owner_q;
                    done1   = owner_q;
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                cnt_reset = 1'b1;
                clr_ack   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign cnt_sel = owner_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: a timeline model predicts every output per cycle,
// plus literal checks on burst lengths, grant order and a simple counter model.
module tb_counter_sched;

    localparam int LEN_W = 8;
    localparam int MAXC  = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, clr_req = 1'b0;
    logic [LEN_W-1:0] len0 = '0, len1 = '0;
    logic ack0, ack1, done0, done1, clr_ack, busy, cnt_sel, cnt_en, cnt_reset;

    counter_sched #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .len0(len0), .req1(req1), .len1(len1), .clr_req(clr_req),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .clr_ack(clr_ack),
        .busy(busy), .cnt_sel(cnt_sel), .cnt_en(cnt_en), .cnt_reset(cnt_reset)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // expected-output timeline, indexed by cycle number
    bit e_ack0[MAXC], e_ack1[MAXC], e_done0[MAXC], e_done1[MAXC];
    bit e_en[MAXC], e_sel[MAXC], e_clr[MAXC];
    int busy_until = 0;
    bit m_last = 1'b1;

    // observations
    int ack0_at = -1, ack1_at = -1, done0_at = -1, done1_at = -1, clr_at = -1;
    int en0_tot = 0, en1_tot = 0;
    int ctr0 = 0, ctr1 = 0, k1 = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic void clear_future(input int from);
        for (int i = from; i < MAXC; i++) begin
            e_ack0[i] = 0; e_ack1[i] = 0; e_done0[i] = 0; e_done1[i] = 0;
            e_en[i] = 0; e_sel[i] = 0; e_clr[i] = 0;
        end
    endfunction

    always @(negedge clk) begin
        bit idle, ch;
        int L;
        idle = (cyc >= busy_until);
        if (reset) begin
            clear_future(cyc);
            busy_until = cyc;
            m_last = 1'b1;
        end else if (idle) begin
            if (clr_req) begin
                e_clr[cyc+1] = 1;
                busy_until = cyc + 2;
            end else if (req0 || req1) begin
                ch = (req0 && req1) ? !m_last : req1;
                m_last = ch;
                L = ch ? int'(len1) : int'(len0);
                if (ch) e_ack1[cyc] = 1; else e_ack0[cyc] = 1;
                for (int i = 1; i <= L; i++) begin
                    e_en[cyc+i] = 1;
                    e_sel[cyc+i] = ch;
                end
                if (ch) e_done1[cyc+L] = 1; else e_done0[cyc+L] = 1;
                busy_until = cyc + L + 1;
            end
        end

        check("ack0", ack0, e_ack0[cyc]);
        check("ack1", ack1, e_ack1[cyc]);
        check("done0", done0, e_done0[cyc]);
        check("done1", done1, e_done1[cyc]);
        check("clr_ack", clr_ack, e_clr[cyc]);
        check("cnt_reset", cnt_reset, e_clr[cyc]);
        check("cnt_en", cnt_en, e_en[cyc]);
        check("busy", busy, !reset && !idle);
        if (e_en[cyc] || reset) check("cnt_sel", cnt_sel, e_sel[cyc]);

        if (ack0) ack0_at = cyc;
        if (ack1) ack1_at = cyc;
        if (done0) done0_at = cyc;
        if (done1) done1_at = cyc;
        if (clr_ack) clr_at = cyc;
        if (cnt_en && !cnt_sel) en0_tot++;
        if (cnt_en && cnt_sel) en1_tot++;

        // reference counter driven by the scheduler's pins
        if (reset || cnt_reset) begin
            ctr0 = 0; ctr1 = 0; k1 = 0;
        end else if (cnt_en) begin
            if (!cnt_sel) ctr0++;
            else begin
                ctr0 = 0;
                k1++;
                if (k1 >= 4 && (k1 - 4) % 3 == 0) ctr1++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 0; req1 = 0; clr_req = 0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // steps until every request has been acknowledged and the block is idle again
    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (1) begin
            step(1);
            n++;
            if (req0 && ack0_at == cyc - 1) req0 = 0;
            if (req1 && ack1_at == cyc - 1) req1 = 0;
            if (clr_req && clr_at == cyc - 1) clr_req = 0;
            if (!req0 && !req1 && !clr_req && !busy) break;
            if (n >= budget) begin
                check("timeout", n, -1);
                req0 = 0; req1 = 0; clr_req = 0;
                break;
            end
        end
    endtask

    initial begin
        #((MAXC - 400) * 10);
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, e0, e1, d1;

        // single channel-0 burst of 5
        do_reset();
        e0 = en0_tot;
        req0 = 1; len0 = 8'd5; t = cyc;
        run_idle(50);
        check("t1_ack_cycle", ack0_at - t, 0);
        check("t1_done_dist", done0_at - ack0_at, 5);
        check("t1_en0", en0_tot - e0, 5);
        check("t1_out0", ctr0, 5);
        check("t1_out1", ctr1, 0);

        // tie from reset: channel 0 first, then channel 1
        do_reset();
        e0 = en0_tot; e1 = en1_tot;
        req0 = 1; req1 = 1; len0 = 8'd2; len1 = 8'd2;
        run_idle(50);
        check("t2_ack_order", ack1_at - ack0_at, 3);
        check("t2_done_order", done1_at - done0_at, 3);
        check("t2_en0", en0_tot - e0, 2);
        check("t2_en1", en1_tot - e1, 2);
        req0 = 1; req1 = 1; len0 = 8'd1; len1 = 8'd1;
        run_idle(50);
        check("t2_next_tie", ack1_at - ack0_at, 2);

        // clear and channel-1 request in the same idle cycle
        e1 = en1_tot;
        clr_req = 1; req1 = 1; len1 = 8'd3; t = cyc;
        run_idle(50);
        check("t3_clr_cycle", clr_at - t, 1);
        check("t3_ack1_cycle", ack1_at - t, 2);
        check("t3_done1_cycle", done1_at - t, 5);
        check("t3_en1", en1_tot - e1, 3);

        // clear raised mid-burst waits for the burst
        e0 = en0_tot;
        req0 = 1; len0 = 8'd4; t = cyc;
        step(1);
        req0 = 0;
        step(1);
        clr_req = 1;
        run_idle(50);
        check("t4_done0", done0_at - t, 4);
        check("t4_clr_after", clr_at - done0_at, 2);
        check("t4_en0", en0_tot - e0, 4);

        // zero-length and maximum-length bursts
        e0 = en0_tot; e1 = en1_tot;
        req1 = 1; len1 = 8'd0; t = cyc;
        run_idle(20);
        check("t5_ack1", ack1_at, t);
        check("t5_done1", done1_at, t);
        check("t5_en1", en1_tot - e1, 0);
        req0 = 1; len0 = 8'd255;
        run_idle(400);
        check("t5_en0_255", en0_tot - e0, 255);
        check("t5_dist_255", done0_at - ack0_at, 255);

        // reset after two enables of a channel-1 burst
        e1 = en1_tot; d1 = done1_at;
        req1 = 1; len1 = 8'd6; t = cyc;
        step(1);
        req1 = 0;
        step(2);
        reset = 1;
        step(2);
        reset = 0;
        step(1);
        check("t6_no_done1", done1_at, d1);
        check("t6_en1", en1_tot - e1, 2);

        // counter semantics: seven channel-1 enables after a clear
        e1 = en1_tot;
        clr_req = 1;
        run_idle(20);
        req1 = 1; len1 = 8'd7;
        run_idle(50);
        check("t6_en1_7", en1_tot - e1, 7);
        check("t6_out1", ctr1, 2);
        check("t6_out0", ctr0, 0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
